wb_sdram_arbiter: RTL and testbench
===================================

Name: wb_sdram_arbiter

Overview:
- Round-robin arbiter that shares the single Wishbone slave port of the SDRAM controller among NUM_MASTERS Wishbone masters.
- Sits between the masters (CPU, DMA, test-bench BFMs) and the SDRAM controller's Wishbone slave.
- Grants one master per bus cycle and holds the grant for the whole cycle, including CTI bursts.
- Muxes request signals to the slave and routes ack/read data back to the granted master only.

Parameters:
- NUM_MASTERS, 2: number of requesting masters, legal range 2..4.
- data_width, 32: Wishbone data width.
- address_width, 26: Wishbone address width.
- TIMEOUT, 255: watchdog limit in cycles; used only when WB_ARB_TIMEOUT_EN is defined.

Ports:
- wb_clk_i  in  1  system clock; all logic on rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- m_cyc_i  in  NUM_MASTERS  per-master cycle request.
- m_stb_i  in  NUM_MASTERS  per-master strobe.
- m_we_i  in  NUM_MASTERS  per-master write enable.
- m_addr_i  in  NUM_MASTERS*address_width  packed addresses; master k occupies slice k.
- m_dat_i  in  NUM_MASTERS*data_width  packed write data.
- m_sel_i  in  NUM_MASTERS*(data_width/8)  packed byte selects.
- m_cti_i  in  NUM_MASTERS*3  packed cycle type identifiers.
- m_ack_o  out  NUM_MASTERS  per-master ack.
- m_err_o  out  NUM_MASTERS  per-master timeout error.
- m_dat_o  out  data_width  read data, common to all masters.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  requests to the SDRAM controller slave.
- s_addr_o  out  address_width  address to the slave.
- s_dat_o  out  data_width  write data to the slave.
- s_sel_o  out  data_width/8  byte selects to the slave.
- s_cti_o  out  3  cycle type to the slave.
- s_ack_i  in  1  ack from the slave.
- s_dat_i  in  data_width  read data from the slave.

Behaviour:
- Clocking and reset: one clock, wb_clk_i. Reset wb_rst_i is synchronous, active-high.
- On reset:
  - State is IDLE; grant register is 0; round-robin pointer is 0, so master 0 has highest priority.
  - Watchdog counter is 0.
  - All s_* outputs, m_ack_o and m_err_o are 0.
- FSM, two states:
  - IDLE -> GRANT when any m_cyc_i bit is 1. The winner is the first requester found scanning from pointer upward, wrapping modulo NUM_MASTERS. The grant is registered.
  - GRANT -> IDLE when m_cyc_i[grant] is 0 at a rising edge. On that transition, pointer = (grant+1) mod NUM_MASTERS.
- Arbitration latency: exactly 1 cycle from m_cyc_i rising in IDLE to s_cyc_o high. Minimum of 1 IDLE cycle between consecutive grants.
- Datapath in GRANT (combinational):
  - s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_dat_o, s_sel_o and s_cti_o equal the granted master's slice.
  - m_ack_o[grant] = s_ack_i; all other m_ack_o bits are 0.
  - m_dat_o = s_dat_i in every state.
- Datapath in IDLE: all s_* outputs are 0; all m_ack_o bits are 0.
- Grant lock: the grant is never changed while m_cyc_i[grant] = 1, regardless of m_stb_i or m_cti_i. Incrementing bursts (cti = 3'b010) and end-of-burst (3'b111) pass through unmodified.
- Non-granted masters stall with ack 0 and are not queued explicitly; fairness comes from pointer rotation only.
- Simultaneous requests: resolved by the pointer. If the granted master drops cyc and another is requesting, the arbiter passes through IDLE for 1 cycle, then grants the next master in rotation.
- Request withdrawn in IDLE before grant: no grant is issued and the pointer is unchanged.
- Reset mid-transaction: the slave cycle aborts the next edge, with s_cyc_o = 0. Any pending ack is dropped, and the pointer returns to 0.
- s_ack_i arriving in IDLE is ignored.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined: a counter clears on entering GRANT and on every s_ack_i, and increments each GRANT cycle without ack. When it reaches TIMEOUT:
  - m_err_o[grant] pulses high for 1 cycle.
  - The FSM forces GRANT -> IDLE and the pointer advances.
  - That master must drop cyc before it can be regranted.
- Not defined: m_err_o is tied to 0, there is no counter, and the grant is held indefinitely.

Test Plan:
- Reset then single write: master 0 writes addr 26'h0000100, data 32'hA5A5_0001. Required: s_cyc_o rises 1 cycle after m_cyc_i[0], slave sees the same address/data, and m_ack_o[0] mirrors s_ack_i.
- Both masters request in the same cycle after reset. Required: master 0 is granted first. After it drops cyc, 1 IDLE cycle follows, then master 1 is granted and the pointer is 0 again.
- Master 1 runs a 4-beat burst (cti 010,010,010,111) from 26'h0000200 while master 0 requests. Required: master 0 sees no ack until master 1 drops cyc, and all 4 beats are acked only to m_ack_o[1].
- Master 0 reads 26'h0000300 with s_dat_i = 32'hDEAD_BEEF. Required: m_dat_o = 32'hDEAD_BEEF in the ack cycle, and m_ack_o[1] = 0 throughout.
- wb_rst_i is asserted 2 cycles into a granted write. Required: next cycle s_cyc_o = 0 and state is IDLE. A new simultaneous request then grants master 0.
- With WB_ARB_TIMEOUT_EN and TIMEOUT = 8, hold s_ack_i = 0. Required: m_err_o[0] pulses at the 8th GRANT cycle, then the arbiter returns to IDLE and the pointer becomes 1.

Source files
------------

// File: rtl/wb_sdram_arbiter_if.sv
// Bus bundle between the Wishbone masters, the arbiter and the SDRAM controller slave port.
// The master modport is the environment's view; the slave modport is the arbiter's view.
interface wb_sdram_arbiter_if #(
  parameter int NUM_MASTERS   = 2,
  parameter int data_width    = 32,
  parameter int address_width = 26
);
  logic [NUM_MASTERS-1:0]                  m_cyc_i;
  logic [NUM_MASTERS-1:0]                  m_stb_i;
  logic [NUM_MASTERS-1:0]                  m_we_i;
  logic [NUM_MASTERS*address_width-1:0]    m_addr_i;
  logic [NUM_MASTERS*data_width-1:0]       m_dat_i;
  logic [NUM_MASTERS*(data_width/8)-1:0]   m_sel_i;
  logic [NUM_MASTERS*3-1:0]                m_cti_i;
  logic [NUM_MASTERS-1:0]                  m_ack_o;
  logic [NUM_MASTERS-1:0]                  m_err_o;
  logic [data_width-1:0]                   m_dat_o;
  logic                                    s_cyc_o;
  logic                                    s_stb_o;
  logic                                    s_we_o;
  logic [address_width-1:0]                s_addr_o;
  logic [data_width-1:0]                   s_dat_o;
  logic [data_width/8-1:0]                 s_sel_o;
  logic [2:0]                              s_cti_o;
  logic                                    s_ack_i;
  logic [data_width-1:0]                   s_dat_i;

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_dat_i, m_sel_i, m_cti_i, s_ack_i, s_dat_i,
    input  m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_dat_o, s_sel_o, s_cti_o
  );

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_dat_i, m_sel_i, m_cti_i, s_ack_i, s_dat_i,
    output m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_dat_o, s_sel_o, s_cti_o
  );
endinterface

// File: rtl/wb_sdram_arbiter.sv
// Round-robin arbiter sharing the SDRAM controller Wishbone slave among NUM_MASTERS masters.
// Optional watchdog with per-master error pulse is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_sdram_arbiter #(
  parameter int NUM_MASTERS   = 2,
  parameter int data_width    = 32,
  parameter int address_width = 26,
  parameter int TIMEOUT       = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  wb_sdram_arbiter_if.slave bus
);

  localparam int GW = (NUM_MASTERS > 2) ? 2 : 1;
  localparam int SW = data_width / 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [GW-1:0]   grant_r;
  logic [GW-1:0]   grant_s;
  logic [GW-1:0]   ptr_r;
  logic [GW-1:0]   ptr_s;
  logic [NUM_MASTERS-1:0] req_s;
  logic            win_found_s;
  logic [GW-1:0]   win_idx_s;
  logic            gnt_cyc_s;
  logic            timeout_s;

  function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] idx);
    if (idx == GW'(NUM_MASTERS - 1)) begin
      return {GW{1'b0}};
    end else begin
      return idx + GW'(1);
    end
  endfunction

  function automatic logic [GW-1:0] rot_idx(input logic [GW-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_MASTERS) begin
      sum = sum - NUM_MASTERS;
    end else begin
      sum = sum;
    end
    return GW'(sum);
  endfunction

`ifdef WB_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [WW-1:0]          wd_cnt_r;
  logic [NUM_MASTERS-1:0] blocked_r;
  logic [NUM_MASTERS-1:0] gnt_onehot_s;

  // A timed-out master stays excluded until it releases cyc.
  assign req_s     = bus.m_cyc_i & ~blocked_r;
  assign timeout_s = (state_r == ST_GRANT) && gnt_cyc_s && !bus.s_ack_i &&
                     (wd_cnt_r == WW'(TIMEOUT - 1));

  // One-hot of the current grant for the block mask.
  always_comb begin
    gnt_onehot_s = {NUM_MASTERS{1'b0}};
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_r == GW'(i)) begin
        gnt_onehot_s[i] = 1'b1;
      end else begin
        gnt_onehot_s[i] = 1'b0;
      end
    end
  end

  // Watchdog counter: counts consecutive ack-less grant cycles.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wd_cnt_r <= {WW{1'b0}};
    end else if ((state_r != ST_GRANT) || bus.s_ack_i || timeout_s) begin
      wd_cnt_r <= {WW{1'b0}};
    end else begin
      wd_cnt_r <= wd_cnt_r + WW'(1);
    end
  end

  // Block mask of masters that timed out and still hold cyc.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      blocked_r <= {NUM_MASTERS{1'b0}};
    end else if (timeout_s) begin
      blocked_r <= (blocked_r & bus.m_cyc_i) | gnt_onehot_s;
    end else begin
      blocked_r <= blocked_r & bus.m_cyc_i;
    end
  end
`else
  assign req_s     = bus.m_cyc_i;
  assign timeout_s = 1'b0;
`endif

  // Round-robin scan from the pointer; lowest rotated offset wins.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {GW{1'b0}};
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (req_s[rot_idx(ptr_r, k)]) begin
        win_found_s = 1'b1;
        win_idx_s   = rot_idx(ptr_r, k);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Cycle request of the currently granted master.
  always_comb begin
    gnt_cyc_s = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_r == GW'(i)) begin
        gnt_cyc_s = bus.m_cyc_i[i];
      end else begin
        gnt_cyc_s = gnt_cyc_s;
      end
    end
  end

  // State, grant and pointer registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r <= ST_IDLE;
      grant_r <= {GW{1'b0}};
      ptr_r   <= {GW{1'b0}};
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
      ptr_r   <= ptr_s;
    end
  end

  // Next-state logic: grant is locked until the owner drops cyc or times out.
  always_comb begin
    state_s = state_r;
    grant_s = grant_r;
    ptr_s   = ptr_r;
    case (state_r)
      ST_IDLE: begin
        if (win_found_s) begin
          state_s = ST_GRANT;
          grant_s = win_idx_s;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!gnt_cyc_s || timeout_s) begin
          state_s = ST_IDLE;
          ptr_s   = next_idx(grant_r);
        end else begin
          state_s = ST_GRANT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output mux: granted master's slice to the slave, ack/err back to that master only.
  always_comb begin
    bus.s_cyc_o  = 1'b0;
    bus.s_stb_o  = 1'b0;
    bus.s_we_o   = 1'b0;
    bus.s_addr_o = {address_width{1'b0}};
    bus.s_dat_o  = {data_width{1'b0}};
    bus.s_sel_o  = {SW{1'b0}};
    bus.s_cti_o  = 3'b000;
    bus.m_ack_o  = {NUM_MASTERS{1'b0}};
    bus.m_err_o  = {NUM_MASTERS{1'b0}};
    bus.m_dat_o  = bus.s_dat_i;
    if (state_r == ST_GRANT) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (grant_r == GW'(i)) begin
          bus.s_cyc_o    = bus.m_cyc_i[i];
          bus.s_stb_o    = bus.m_stb_i[i];
          bus.s_we_o     = bus.m_we_i[i];
          bus.s_addr_o   = bus.m_addr_i[i*address_width +: address_width];
          bus.s_dat_o    = bus.m_dat_i[i*data_width +: data_width];
          bus.s_sel_o    = bus.m_sel_i[i*SW +: SW];
          bus.s_cti_o    = bus.m_cti_i[i*3 +: 3];
          bus.m_ack_o[i] = bus.s_ack_i;
          bus.m_err_o[i] = timeout_s;
        end else begin
          bus.m_ack_o[i] = 1'b0;
          bus.m_err_o[i] = 1'b0;
        end
      end
    end else begin
      bus.m_ack_o = {NUM_MASTERS{1'b0}};
      bus.m_err_o = {NUM_MASTERS{1'b0}};
    end
  end

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Directed bench for wb_sdram_arbiter: stimulus pushes expected responses, a monitor
// pops them whenever the arbiter presents ack or err to a master.
module tb_wb_sdram_arbiter;

  localparam int NM = 2;
  localparam int AW = 26;
  localparam int DW = 32;

  typedef struct {
    logic [NM-1:0] ack;
    logic [NM-1:0] err;
    logic [DW-1:0] dat;
    logic [AW-1:0] addr;
    logic [2:0]    cti;
    logic          we;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  wb_sdram_arbiter_if #(.NUM_MASTERS(NM), .data_width(DW), .address_width(AW)) bus ();

  wb_sdram_arbiter #(
    .NUM_MASTERS(NM), .data_width(DW), .address_width(AW), .TIMEOUT(8)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic set_m(input int m, input logic cyc, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [2:0] cti);
    bus.m_cyc_i[m]            = cyc;
    bus.m_stb_i[m]            = cyc;
    bus.m_we_i[m]             = we;
    bus.m_addr_i[m*AW +: AW]  = a;
    bus.m_dat_i[m*DW +: DW]   = d;
    bus.m_sel_i[m*4 +: 4]     = 4'hF;
    bus.m_cti_i[m*3 +: 3]     = cti;
  endtask

  task automatic drop(input int m);
    set_m(m, 1'b0, 1'b0, 26'h0, 32'h0, 3'b000);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    drop(0);
    drop(1);
    bus.s_ack_i = 1'b0;
    bus.s_dat_i = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    at_neg();
    chk("rst_s_cyc", 64'(bus.s_cyc_o), 64'(0));
    chk("rst_s_addr", 64'(bus.s_addr_o), 64'(0));
    chk("rst_m_ack", 64'(bus.m_ack_o), 64'(0));
    chk("rst_m_err", 64'(bus.m_err_o), 64'(0));
    tick();
  endtask

  // One acked beat for the granted master m; the expected response goes to the scoreboard.
  task automatic beat(input int m, input logic [DW-1:0] rd);
    exp_t e;
    e.ack    = '0;
    e.ack[m] = 1'b1;
    e.err    = '0;
    e.dat    = rd;
    e.addr   = bus.m_addr_i[m*AW +: AW];
    e.cti    = bus.m_cti_i[m*3 +: 3];
    e.we     = bus.m_we_i[m];
    exp_q.push_back(e);
    bus.s_ack_i = 1'b1;
    bus.s_dat_i = rd;
    at_neg();
    tick();
    bus.s_ack_i = 1'b0;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst && ((|bus.m_ack_o) || (|bus.m_err_o))) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp ack %b err %b", bus.m_ack_o, bus.m_err_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_ack", 64'(bus.m_ack_o), 64'(mon_e.ack));
        chk("resp_err", 64'(bus.m_err_o), 64'(mon_e.err));
        chk("resp_dat", 64'(bus.m_dat_o), 64'(mon_e.dat));
        chk("resp_addr", 64'(bus.s_addr_o), 64'(mon_e.addr));
        chk("resp_cti", 64'(bus.s_cti_o), 64'(mon_e.cti));
        chk("resp_we", 64'(bus.s_we_o), 64'(mon_e.we));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit exceeded");
    $fatal(1, "time limit");
  end

  initial begin
    logic [AW-1:0] burst_addr;
    logic [2:0]    burst_cti;
    rst = 1'b1;
    do_reset();

    // Single write from master 0.
    set_m(0, 1'b1, 1'b1, 26'h0000100, 32'hA5A5_0001, 3'b000);
    at_neg();
    chk("lat_idle_cycle", 64'(bus.s_cyc_o), 64'(0));
    tick();
    at_neg();
    chk("wr_s_cyc", 64'(bus.s_cyc_o), 64'(1));
    chk("wr_s_addr", 64'(bus.s_addr_o), 64'(26'h0000100));
    chk("wr_s_dat", 64'(bus.s_dat_o), 64'(32'hA5A5_0001));
    chk("wr_s_sel", 64'(bus.s_sel_o), 64'(4'hF));
    chk("wr_no_ack", 64'(bus.m_ack_o), 64'(0));
    tick();
    beat(0, 32'h0);
    drop(0);
    at_neg();
    chk("wr_drop_s_cyc", 64'(bus.s_cyc_o), 64'(0));
    tick();

    // Simultaneous requests after reset.
    do_reset();
    set_m(0, 1'b1, 1'b1, 26'h0000010, 32'h1111_0000, 3'b000);
    set_m(1, 1'b1, 1'b1, 26'h0000020, 32'h2222_0000, 3'b000);
    tick();
    at_neg();
    chk("sim_first_m0", 64'(bus.s_addr_o), 64'(26'h0000010));
    tick();
    beat(0, 32'h0);
    drop(0);
    tick();
    at_neg();
    chk("sim_idle_gap", 64'(bus.s_cyc_o), 64'(0));
    tick();
    at_neg();
    chk("sim_then_m1", 64'(bus.s_addr_o), 64'(26'h0000020));
    chk("sim_m1_dat", 64'(bus.s_dat_o), 64'(32'h2222_0000));
    tick();
    beat(1, 32'h0);
    drop(1);
    tick();
    set_m(0, 1'b1, 1'b1, 26'h0000010, 32'h1111_0000, 3'b000);
    set_m(1, 1'b1, 1'b1, 26'h0000020, 32'h2222_0000, 3'b000);
    tick();
    at_neg();
    chk("ptr_back_to_0", 64'(bus.s_addr_o), 64'(26'h0000010));
    drop(0);
    drop(1);
    tick();

    // Master 1 burst while master 0 waits with a read (pointer is now 1).
    set_m(1, 1'b1, 1'b1, 26'h0000200, 32'hB000_0000, 3'b010);
    set_m(0, 1'b1, 1'b0, 26'h0000300, 32'h0, 3'b000);
    tick();
    for (int b = 0; b < 4; b++) begin
      burst_addr = 26'h0000200 + AW'(4 * b);
      burst_cti  = (b == 3) ? 3'b111 : 3'b010;
      set_m(1, 1'b1, 1'b1, burst_addr, 32'hB000_0000 + DW'(b), burst_cti);
      beat(1, 32'h0);
    end
    drop(1);
    at_neg();
    chk("burst_m0_no_ack", 64'(bus.m_ack_o), 64'(0));
    chk("burst_end_s_cyc", 64'(bus.s_cyc_o), 64'(0));
    tick();
    at_neg();
    chk("burst_idle_gap", 64'(bus.s_cyc_o), 64'(0));
    tick();

    // Master 0 read.
    at_neg();
    chk("rd_s_addr", 64'(bus.s_addr_o), 64'(26'h0000300));
    chk("rd_s_we", 64'(bus.s_we_o), 64'(0));
    tick();
    beat(0, 32'hDEAD_BEEF);
    drop(0);
    tick();
    bus.s_ack_i = 1'b1;
    at_neg();
    chk("ack_in_idle", 64'(bus.m_ack_o), 64'(0));
    tick();
    bus.s_ack_i = 1'b0;

    // Reset two cycles into a granted write (pointer is 1 here).
    set_m(1, 1'b1, 1'b1, 26'h0000400, 32'h4444_0000, 3'b000);
    tick();
    at_neg();
    chk("rstmid_granted", 64'(bus.s_cyc_o), 64'(1));
    tick();
    rst = 1'b1;
    at_neg();
    tick();
    at_neg();
    chk("rstmid_s_cyc", 64'(bus.s_cyc_o), 64'(0));
    chk("rstmid_m_ack", 64'(bus.m_ack_o), 64'(0));
    rst = 1'b0;
    set_m(0, 1'b1, 1'b1, 26'h0000500, 32'h5555_0000, 3'b000);
    tick();
    at_neg();
    chk("rstmid_regrant_m0", 64'(bus.s_addr_o), 64'(26'h0000500));
    tick();
    beat(0, 32'h0);
    drop(0);
    drop(1);
    tick();

`ifdef WB_ARB_TIMEOUT_EN
    // Watchdog: no ack for TIMEOUT grant cycles.
    do_reset();
    set_m(0, 1'b1, 1'b1, 26'h0000600, 32'h6666_0000, 3'b000);
    tick();
    for (int c = 1; c <= 8; c++) begin
      if (c == 8) begin
        exp_q.push_back('{ack: 2'b00, err: 2'b01, dat: 32'h0, addr: 26'h0000600, cti: 3'b000, we: 1'b1});
      end
      at_neg();
      if (c < 8) begin
        chk("to_no_err_early", 64'(bus.m_err_o), 64'(0));
      end
      tick();
    end
    at_neg();
    chk("to_back_idle", 64'(bus.s_cyc_o), 64'(0));
    tick();
    at_neg();
    chk("to_m0_blocked", 64'(bus.s_cyc_o), 64'(0));
    drop(0);
    tick();
    set_m(0, 1'b1, 1'b1, 26'h0000600, 32'h6666_0000, 3'b000);
    set_m(1, 1'b1, 1'b1, 26'h0000700, 32'h7777_0000, 3'b000);
    tick();
    at_neg();
    chk("to_ptr_is_1", 64'(bus.s_addr_o), 64'(26'h0000700));
    drop(0);
    drop(1);
    tick();
`else
    // Without the watchdog the grant is held indefinitely and err never fires.
    do_reset();
    set_m(0, 1'b1, 1'b1, 26'h0000600, 32'h6666_0000, 3'b000);
    tick();
    for (int c = 1; c <= 20; c++) begin
      at_neg();
      chk("hold_no_err", 64'(bus.m_err_o), 64'(0));
      chk("hold_s_cyc", 64'(bus.s_cyc_o), 64'(1));
      tick();
    end
    drop(0);
    tick();
`endif

    at_neg();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
